ram_access_ctrl: RTL and testbench

Request-side controller sitting directly upstream of the team's single-port synchronous RAM. It accepts read, write and block-fill commands over a valid/ready handshake and sequences the RAM's chip-select, write-enable, output-enable, address and bidirectional data pins. It returns read data with a single-cycle response pulse. It is the only master of the RAM bus, so bus contention is excluded by construction.

---
 rtl/ram_access_ctrl_if.sv | 25 ++
 rtl/ram_access_ctrl.sv | 130 +++++++++++++
 tb/tb_ram_access_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/ram_access_ctrl_if.sv
// rtl/ram_access_ctrl_if.sv - command/response handshake bundle for ram_access_ctrl
interface ram_access_ctrl_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1
);
    logic                  req_valid;
    logic                  req_ready;
    logic [1:0]            req_op;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [LEN_WIDTH-1:0]  req_count;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;

    modport master (
        output req_valid, req_op, req_addr, req_wdata, req_count,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, req_count,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/ram_access_ctrl.sv
// rtl/ram_access_ctrl.sv - read/write/fill sequencer driving a single-port synchronous RAM
module ram_access_ctrl #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ram_access_ctrl_if.slave      bus,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    inout  wire  [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe
);
    typedef enum logic [2:0] {IDLE, RD, WR, FILL, RESP} state_t;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_FILL  = 2'b10;

    state_t                state, state_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [LEN_WIDTH-1:0]  remain_q, remain_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic                  cs_d, we_d, oe_d;

    assign bus.req_ready = (state == IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rdata_q;

    // Data pins are only driven from the registered write enable, so the bus
    // floats in every cycle that is not a RAM write.
    assign ram_data = ram_we ? wdata_q : {DATA_WIDTH{1'bz}};

    always_comb begin
        state_d     = state;
        wdata_d     = wdata_q;
        remain_d    = remain_q;
        rdata_d     = rdata_q;
        rsp_valid_d = 1'b0;
        addr_d      = ram_addr;
        cs_d        = 1'b0;
        we_d        = 1'b0;
        oe_d        = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    wdata_d  = bus.req_wdata;
                    addr_d   = bus.req_addr;
                    remain_d = bus.req_count;
                    case (bus.req_op)
                        OP_READ: begin
                            state_d = RD;
                            cs_d    = 1'b1;
                            oe_d    = 1'b1;
                        end
                        OP_WRITE: begin
                            state_d = WR;
                            cs_d    = 1'b1;
                            we_d    = 1'b1;
                        end
                        OP_FILL: begin
                            if (bus.req_count != '0) begin
                                state_d = FILL;
                                cs_d    = 1'b1;
                                we_d    = 1'b1;
                            end else begin
                                state_d = RESP;
                            end
                        end
                        default: state_d = RESP;
                    endcase
                end
            end
            RD: begin
                rdata_d     = ram_data;
                rsp_valid_d = 1'b1;
                state_d     = IDLE;
            end
            WR: begin
                rsp_valid_d = 1'b1;
                state_d     = IDLE;
            end
            FILL: begin
                // The RAM commits the current word on this edge; stop once the last one lands.
                addr_d   = ram_addr + ADDR_WIDTH'(1);
                remain_d = remain_q - LEN_WIDTH'(1);
                if (remain_q == LEN_WIDTH'(1)) begin
                    rsp_valid_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    cs_d = 1'b1;
                    we_d = 1'b1;
                end
            end
            RESP: begin
                rsp_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            wdata_q     <= '0;
            remain_q    <= '0;
            rdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            ram_addr    <= '0;
            ram_cs      <= 1'b0;
            ram_we      <= 1'b0;
            ram_oe      <= 1'b0;
        end else begin
            state       <= state_d;
            wdata_q     <= wdata_d;
            remain_q    <= remain_d;
            rdata_q     <= rdata_d;
            rsp_valid_q <= rsp_valid_d;
            ram_addr    <= addr_d;
            ram_cs      <= cs_d;
            ram_we      <= we_d;
            ram_oe      <= oe_d;
        end
    end
endmodule

// File: tb/tb_ram_access_ctrl.sv
// tb/tb_ram_access_ctrl.sv - scoreboard bench for ram_access_ctrl with a behavioural RAM
module tb_ram_access_ctrl;
    localparam int AW = 6;
    localparam int DW = 8;
    localparam int LW = 7;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ram_access_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

    logic [AW-1:0] ram_addr;
    wire  [DW-1:0] ram_data;
    logic          ram_cs, ram_we, ram_oe;

    ram_access_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .ram_addr (ram_addr),
        .ram_data (ram_data),
        .ram_cs   (ram_cs),
        .ram_we   (ram_we),
        .ram_oe   (ram_oe)
    );

    // Behavioural single-port RAM: read data latched on the falling edge, writes on the rising edge.
    logic [DW-1:0] mem [64];
    logic [DW-1:0] rd_q;
    initial begin
        for (int i = 0; i < 64; i++) mem[i] = '0;
        rd_q = '0;
    end
    always @(negedge clk) if (ram_cs && ram_oe && !ram_we) rd_q <= mem[ram_addr];
    always @(posedge clk) if (ram_cs && ram_we) mem[ram_addr] <= ram_data;
    assign ram_data = (ram_cs && ram_oe && !ram_we) ? rd_q : {DW{1'bz}};

    typedef struct {
        int            due;
        logic [DW-1:0] rdata;
        string         name;
    } exp_t;

    exp_t          sbq[$];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            last_k = 0;
    logic [DW-1:0] last_rd = '0;
    bit            overlap_seen = 1'b0;
    bit            cs_seen = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (ram_we && ram_oe) overlap_seen = 1'b1;
            if (ram_cs) cs_seen = 1'b1;
            if (rst_n && bus.rsp_valid) begin
                if (sbq.size() == 0) begin
                    check("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    check({e.name, "_latency"}, 32'(cyc), 32'(e.due));
                    check({e.name, "_rdata"}, 32'(bus.rsp_rdata), 32'(e.rdata));
                end
            end
        end
    end

    // Called at a falling edge; returns at the falling edge after the accepting rising edge.
    task automatic issue(input string name, input logic [1:0] op, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd, input logic [LW-1:0] cnt, input bit is_rd,
                         input logic [DW-1:0] exp_rd, input int lat, input bit keep);
        int   n;
        exp_t e;
        n = 0;
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        bus.req_count = cnt;
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            check({name, "_accept_timeout"}, 32'd0, 32'd1);
            bus.req_valid = 1'b0;
            return;
        end
        last_k = cyc + 1;
        if (is_rd) last_rd = exp_rd;
        e.due   = last_k + lat;
        e.rdata = last_rd;
        e.name  = name;
        sbq.push_back(e);
        @(posedge clk);
        @(negedge clk);
        if (!keep) bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0) begin
            check("drain_timeout", 32'(sbq.size()), 32'd0);
            sbq.delete();
        end
        @(negedge clk);
    endtask

    initial begin : stimulus
        int prev_k;
        bus.req_valid = 1'b0;
        bus.req_op    = 2'b00;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_count = '0;
        repeat (3) @(negedge clk);

        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_ram_ctrl", {29'd0, ram_cs, ram_we, ram_oe}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        issue("wr_a5", 2'b01, 6'h12, 8'hA5, 7'd0, 1'b0, 8'h00, 1, 1'b0);
        issue("rd_a5", 2'b00, 6'h12, 8'h00, 7'd0, 1'b1, 8'hA5, 1, 1'b0);
        drain();

        prev_k = 0;
        for (int i = 0; i < 8; i++) begin
            if (i < 4)
                issue("b2b_wr", 2'b01, 6'(i), 8'(i + 1), 7'd0, 1'b0, 8'h00, 1, 1'b1);
            else
                issue("b2b_rd", 2'b00, 6'(i - 4), 8'h00, 7'd0, 1'b1, 8'(i - 3), 1, i != 7);
            if (i > 0) check("b2b_accept_spacing", 32'(last_k - prev_k), 32'd2);
            prev_k = last_k;
        end
        drain();

        issue("fill_wrap", 2'b10, 6'h3E, 8'h55, 7'd4, 1'b0, 8'h00, 4, 1'b0);
        drain();
        issue("wrap_rd_3e", 2'b00, 6'h3E, 8'h00, 7'd0, 1'b1, 8'h55, 1, 1'b0);
        issue("wrap_rd_3f", 2'b00, 6'h3F, 8'h00, 7'd0, 1'b1, 8'h55, 1, 1'b0);
        issue("wrap_rd_00", 2'b00, 6'h00, 8'h00, 7'd0, 1'b1, 8'h55, 1, 1'b0);
        issue("wrap_rd_01", 2'b00, 6'h01, 8'h00, 7'd0, 1'b1, 8'h55, 1, 1'b0);
        issue("wrap_rd_02", 2'b00, 6'h02, 8'h00, 7'd0, 1'b1, 8'h03, 1, 1'b0);
        drain();

        cs_seen = 1'b0;
        issue("fill_zero", 2'b10, 6'h05, 8'hEE, 7'd0, 1'b0, 8'h00, 1, 1'b0);
        issue("op_rsvd", 2'b11, 6'h06, 8'hEE, 7'd5, 1'b0, 8'h00, 1, 1'b0);
        drain();
        check("zero_rsvd_cs_idle", 32'(cs_seen), 32'd0);

        issue("fill_full", 2'b10, 6'h20, 8'hFF, 7'd64, 1'b0, 8'h00, 64, 1'b0);
        drain();
        for (int a = 0; a < 64; a++)
            issue("full_rd", 2'b00, 6'(a), 8'h00, 7'd0, 1'b1, 8'hFF, 1, 1'b0);
        drain();

        // Abort a fill after three words have been written (0x20..0x22).
        issue("fill_abort", 2'b10, 6'h20, 8'h11, 7'd10, 1'b0, 8'h00, 10, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_ram_ctrl", {29'd0, ram_cs, ram_we, ram_oe}, 32'd0);
        check("abort_ram_addr", 32'(ram_addr), 32'd0);
        check("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("abort_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
        sbq.delete();
        last_rd = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_req_ready", 32'(bus.req_ready), 32'd1);
        issue("abort_rd_20", 2'b00, 6'h20, 8'h00, 7'd0, 1'b1, 8'h11, 1, 1'b0);
        issue("abort_rd_22", 2'b00, 6'h22, 8'h00, 7'd0, 1'b1, 8'h11, 1, 1'b0);
        issue("abort_rd_23", 2'b00, 6'h23, 8'h00, 7'd0, 1'b1, 8'hFF, 1, 1'b0);
        drain();

        check("we_oe_exclusive", 32'(overlap_seen), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
